// File: rtl/spi_responder_pkg.sv
// Shared types and constants for the SPI register responder.
package spi_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WDATA,
    RDATA
  } state_e;

  localparam int CMD_READ_BIT = 7;
  localparam int ADDR_W       = 7;
  localparam int DATA_W       = 8;

endpackage

// File: rtl/spi_input_sync.sv
// Synchronizes the asynchronous SPI pins into clk_48mhz and derives edge strobes.
module spi_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_48mhz,
  input  logic reset,
  input  logic spi_sck,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_active,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] cs_n_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sck_prev_q;
  logic                   cs_n_prev_q;
  logic                   sck_s;
  logic                   cs_n_s;

  // CS is assumed asserted out of reset, so a frame already in flight is never
  // joined mid-byte: a fresh falling edge is needed to start the next frame.
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      sck_sync_q  <= '0;
      cs_n_sync_q <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_n_prev_q <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      cs_n_sync_q <= {cs_n_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
      cs_n_prev_q <= cs_n_sync_q[SYNC_STAGES-1];
    end
  end

  assign sck_s     = sck_sync_q[SYNC_STAGES-1];
  assign cs_n_s    = cs_n_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_prev_q;
  assign sck_fall  = ~sck_s & sck_prev_q;
  assign cs_active = ~cs_n_s;
  assign cs_fall   = ~cs_n_s & cs_n_prev_q;
  assign cs_rise   = cs_n_s & ~cs_n_prev_q;

endmodule

// File: rtl/spi_register_responder.sv
// SPI mode-0 target giving an external host read/write access to a 128-byte
// register space, with auto-incrementing address bursts.
module spi_register_responder
  import spi_responder_pkg::*;
#(
  parameter logic [7:0] SIGNATURE   = 8'hA5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk_48mhz,
  input  logic              reset,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic              frame_err
);

  logic sck_rise, sck_fall, cs_active, cs_fall, cs_rise, mosi_s;

  spi_input_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_48mhz(clk_48mhz),
    .reset    (reset),
    .spi_sck  (spi_sck),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .cs_active(cs_active),
    .cs_fall  (cs_fall),
    .cs_rise  (cs_rise),
    .mosi_s   (mosi_s)
  );

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              cap_q, cap_d;
  logic              inc_q, inc_d;
  logic              ferr_q, ferr_d;
  logic [DATA_W-1:0] rx_byte;
  logic              byte_done;

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      cap_q      <= 1'b0;
      inc_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      re_q       <= re_d;
      cap_q      <= cap_d;
      inc_q      <= inc_d;
      ferr_q     <= ferr_d;
    end
  end

  assign rx_byte   = {rx_shift_q[DATA_W-2:0], mosi_s};
  assign byte_done = sck_rise && (bit_cnt_q == 3'd7);

  // Read data lands the cycle after the strobe, and the address steps only once
  // the access it belongs to has finished; both run on regardless of CS.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    ferr_d     = 1'b0;
    cap_d      = re_q;
    inc_d      = cap_q | we_q;

    if (cap_q) tx_shift_d = reg_rdata;
    if (inc_q) addr_d = addr_q + 7'd1;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = CMD;
          tx_shift_d = SIGNATURE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
        end
      end
      default: begin
        if (cs_rise) begin
          state_d   = IDLE;
          ferr_d    = (bit_cnt_q != 3'd0);
          bit_cnt_d = '0;
        end else begin
          if (sck_rise) begin
            rx_shift_d = rx_byte;
            bit_cnt_d  = bit_cnt_q + 3'd1;
          end
          // The first falling edge of a byte leaves the freshly loaded MSB in place.
          if (sck_fall && (bit_cnt_q != 3'd0)) begin
            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          end
          if (byte_done) begin
            case (state_q)
              CMD: begin
                addr_d = rx_byte[ADDR_W-1:0];
                if (rx_byte[CMD_READ_BIT]) begin
                  state_d = RDATA;
                  re_d    = 1'b1;
                end else begin
                  state_d    = WDATA;
                  tx_shift_d = '0;
                end
              end
              WDATA: begin
                wdata_d    = rx_byte;
                we_d       = 1'b1;
                tx_shift_d = '0;
              end
              RDATA:   re_d = 1'b1;
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  assign spi_miso    = tx_shift_q[DATA_W-1];
  assign busy        = cs_active && (state_q != IDLE);
  assign spi_miso_oe = busy;
  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;
  assign reg_we      = we_q;
  assign reg_re      = re_q;
  assign frame_err   = ferr_q;

endmodule

// File: tb/tb_spi_register_responder.sv
// Scoreboard bench: a bit-banged SPI host plus a register-file model drive the
// responder; expected strobes and MISO bytes are queued and checked as they appear.
module tb_spi_register_responder;

  localparam int HALF = 80;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sck = 1'b0;
  logic       csN = 1'b1;
  logic       mosi = 1'b0;
  logic       spiMiso, spiMisoOe, regWe, regRe, busy, frameErr;
  logic [6:0] regAddr;
  logic [7:0] regWdata;
  logic [7:0] regRdata = 8'h00;

  always #10 clk = ~clk;

  spi_register_responder dut (
    .clk_48mhz  (clk),
    .reset      (reset),
    .spi_sck    (sck),
    .spi_cs_n   (csN),
    .spi_mosi   (mosi),
    .spi_miso   (spiMiso),
    .spi_miso_oe(spiMisoOe),
    .reg_addr   (regAddr),
    .reg_wdata  (regWdata),
    .reg_we     (regWe),
    .reg_re     (regRe),
    .reg_rdata  (regRdata),
    .busy       (busy),
    .frame_err  (frameErr)
  );

  logic [7:0]  devMem [128];
  logic [7:0]  refMem [128];
  logic [14:0] weQ [$];
  logic [6:0]  reQ [$];
  int          errQ [$];
  logic [7:0]  misoQ [$];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Register file seen by the responder: data is valid the cycle after reg_re,
  // and garbage otherwise so a mistimed capture shows up.
  always @(posedge clk) begin
    if (regRe) regRdata <= devMem[regAddr];
    else regRdata <= 8'($urandom);
    if (regWe) devMem[regAddr] <= regWdata;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (regWe) begin
        if (weQ.size() == 0) checkOutput("reg_we_unexpected", regWe, 0);
        else checkOutput("reg_we_addr_data", {regAddr, regWdata}, weQ.pop_front());
      end
      if (regRe) begin
        if (reQ.size() == 0) checkOutput("reg_re_unexpected", regRe, 0);
        else checkOutput("reg_re_addr", regAddr, reQ.pop_front());
      end
      if (regWe && regRe) checkOutput("we_re_exclusive", regRe, 0);
      if (frameErr) begin
        if (errQ.size() == 0) checkOutput("frame_err_unexpected", frameErr, 0);
        else void'(errQ.pop_front());
      end
    end
  end

  task automatic pulseResetAndCheck();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_miso", spiMiso, 0);
    checkOutput("rst_miso_oe", spiMisoOe, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_addr", regAddr, 0);
    checkOutput("rst_wdata", regWdata, 0);
    checkOutput("rst_we", regWe, 0);
    checkOutput("rst_re", regRe, 0);
    checkOutput("rst_frame_err", frameErr, 0);
    reset = 1'b0;
    #3;
  endtask

  task automatic applyStimulus(input bit isRead, input logic [6:0] addr, input logic [7:0] data[$],
                               input int abortBits, input int resetAtByte);
    int         nData = data.size();
    int         fullBytes = 1 + nData;
    int         checkedBytes = (resetAtByte >= 0) ? resetAtByte : fullBytes;
    int         totalBytes = fullBytes + ((abortBits > 0) ? 1 : 0);
    logic [6:0] a;
    logic [7:0] txByte, rx, pre;
    int         nBits;

    for (int b = 0; b < checkedBytes; b++) begin
      a = addr + 7'(b - 1);
      if (b == 0) misoQ.push_back(8'hA5);
      else misoQ.push_back(isRead ? refMem[a] : 8'h00);
    end
    if (isRead) begin
      for (int k = 0; k < checkedBytes; k++) reQ.push_back(addr + 7'(k));
    end else begin
      for (int k = 1; k < checkedBytes; k++) begin
        a = addr + 7'(k - 1);
        weQ.push_back({a, data[k-1]});
        refMem[a] = data[k-1];
      end
    end
    if (abortBits > 0 && resetAtByte < 0) errQ.push_back(1);

    @(posedge clk);
    #(1 + 2 * $urandom_range(0, 9));
    csN = 1'b0;
    #(2 * HALF);
    for (int b = 0; b < totalBytes; b++) begin
      if (b == 0) txByte = {isRead, addr};
      else if (b - 1 < nData) txByte = data[b-1];
      else txByte = 8'($urandom);
      nBits = (b == fullBytes) ? abortBits : 8;
      rx = 8'h00;
      for (int i = 0; i < nBits; i++) begin
        if (b == resetAtByte && i == 3) pulseResetAndCheck();
        mosi = txByte[7-i];
        #(HALF - 10);
        pre = {7'd0, spiMiso};
        #10;
        rx = {rx[6:0], spiMiso};
        if (b < checkedBytes) checkOutput("miso_stable", spiMiso, pre[0]);
        if (b == 0 && i == 0) checkOutput("miso_oe_in_frame", spiMisoOe, 1);
        sck = 1'b1;
        #HALF;
        sck = 1'b0;
      end
      if (nBits == 8 && b < checkedBytes) checkOutput("miso_byte", rx, misoQ.pop_front());
    end
    #HALF;
    csN = 1'b1;
    #(2 * HALF);
    checkOutput("busy_after_frame", busy, 0);
    checkOutput("we_pending", weQ.size(), 0);
    checkOutput("re_pending", reQ.size(), 0);
    checkOutput("frame_err_pending", errQ.size(), 0);
  endtask

  initial begin
    logic [7:0] d[$];
    int         n;

    for (int i = 0; i < 128; i++) begin
      devMem[i] = 8'(i) ^ 8'hFF;
      refMem[i] = 8'(i) ^ 8'hFF;
    end

    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("init_miso", spiMiso, 0);
    checkOutput("init_miso_oe", spiMisoOe, 0);
    checkOutput("init_addr", regAddr, 0);
    checkOutput("init_wdata", regWdata, 0);
    checkOutput("init_we", regWe, 0);
    checkOutput("init_re", regRe, 0);
    checkOutput("init_busy", busy, 0);
    checkOutput("init_frame_err", frameErr, 0);

    $display("[TB] write burst");
    d.delete(); d.push_back(8'h11); d.push_back(8'h22); d.push_back(8'h33);
    applyStimulus(1'b0, 7'h05, d, 0, -1);

    $display("[TB] read burst");
    d.delete(); repeat (3) d.push_back(8'h00);
    applyStimulus(1'b1, 7'h10, d, 0, -1);

    $display("[TB] address wrap");
    d.delete(); d.push_back(8'hAA); d.push_back(8'hBB);
    applyStimulus(1'b0, 7'h7F, d, 0, -1);
    d.delete(); d.push_back(8'h00); d.push_back(8'h00);
    applyStimulus(1'b1, 7'h7F, d, 0, -1);

    $display("[TB] abort mid-byte");
    d.delete();
    applyStimulus(1'b0, 7'h20, d, 4, -1);
    d.delete(); d.push_back(8'h5C);
    applyStimulus(1'b0, 7'h21, d, 0, -1);

    $display("[TB] reset mid-read");
    d.delete(); repeat (3) d.push_back(8'h00);
    applyStimulus(1'b1, 7'h30, d, 0, 2);
    applyStimulus(1'b1, 7'h20, d, 0, -1);

    $display("[TB] random frames");
    for (int f = 0; f < 250; f++) begin
      d.delete();
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) d.push_back(8'($urandom));
      applyStimulus(1'($urandom), 7'($urandom),
                    d, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 7)) : 0, -1);
    end

    repeat (20) @(negedge clk);
    checkOutput("final_miso_queue", misoQ.size(), 0);
    checkOutput("final_we_queue", weQ.size(), 0);
    checkOutput("final_re_queue", reQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
